// File: rtl/pipe_ctrl_if.sv
// Run-control and hazard bus between the pipeline datapath and pipe_ctrl.
// The master side drives requests and hazard sources; the slave side (pipe_ctrl) returns enables, flushes and status.
interface pipe_ctrl_if #(
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
);
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic [STEP_W-1:0] step_num;
  logic              cnt_clr;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [4:0]        ex_rd;
  logic              ex_mem_read;
  logic              branch_taken;
  logic              pc_en;
  logic              if_id_en;
  logic              pipe_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              halted;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output run_req, halt_req, step_req, step_num, cnt_clr,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, branch_taken,
    input  pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
           halted, state, stall_count, flush_count
  );

  modport slave (
    input  run_req, halt_req, step_req, step_num, cnt_clr,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read, branch_taken,
    output pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
           halted, state, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Run-control and hazard sequencer for the 5-stage pipeline: halt/run/step control,
// load-use bubble insertion, taken-branch squash and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int STEP_W    = 8,
  parameter int CNT_W     = 16,
  parameter bit START_RUN = 1'b1
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  state_t            state_q;
  logic [STEP_W-1:0] remaining;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic active;
  logic load_use;
  logic do_branch;
  logic do_stall;

  assign active = (state_q == ST_RUN) || ((state_q == ST_STEP) && (remaining != '0));

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // A taken branch squashes the instruction that caused the hazard, so it masks the stall.
  assign do_branch = active && bus.branch_taken;
  assign do_stall  = active && load_use && !bus.branch_taken;

  always_comb begin
    bus.pc_en        = active;
    bus.if_id_en     = active;
    bus.pipe_en      = active;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    if (do_branch) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (do_stall) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      remaining <= '0;
    end else if (bus.halt_req) begin
      state_q   <= ST_HALT;
      remaining <= '0;
    end else if (bus.run_req) begin
      state_q   <= ST_RUN;
      remaining <= '0;
    end else if (bus.step_req && (state_q == ST_HALT)) begin
      state_q   <= ST_STEP;
      remaining <= (bus.step_num == '0) ? STEP_W'(1) : bus.step_num;
    end else if (state_q == ST_STEP) begin
      // Steps count clock cycles, so stall and flush cycles consume them too.
      if (remaining <= STEP_W'(1)) begin
        state_q   <= ST_HALT;
        remaining <= '0;
      end else begin
        remaining <= remaining - STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (active) begin
      if (bus.cnt_clr) begin
        stall_q <= '0;
        flush_q <= '0;
      end else begin
        if (do_stall && !(&stall_q)) begin
          stall_q <= stall_q + CNT_W'(1);
        end
        if (do_branch && !(&flush_q)) begin
          flush_q <= flush_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.halted      = (state_q == ST_HALT);
  assign bus.state       = state_q;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Run-control and hazard sequencer for the 5-stage RV32I pipeline (FETCH, DECO, EXE, MEM, WR). It generates the PC and pipeline-register enables and flushes, inserts one bubble on load-use hazards, and squashes the three younger instructions when MEM resolves a taken branch. It also provides halt/run/cycle-step control, driven by the board buttons, so register contents can be inspected on the display between steps. It also provides saturating stall and flush counters.

## Interface
- STEP_W, 8, width of step_num and of the internal step counter
- CNT_W, 16, width of stall_count / flush_count
- START_RUN, 1, state after reset: 1 = RUN, 0 = HALT
- clk  in  1  system clock, all flops rising edge
- rst  in  1  asynchronous, active-high reset
- run_req  in  1  single-cycle pulse: enter RUN
- halt_req  in  1  single-cycle pulse: enter HALT
- step_req  in  1  single-cycle pulse: execute step_num active cycles, then HALT
- step_num  in  STEP_W  cycles per step; 0 treated as 1
- cnt_clr  in  1  synchronous clear of both counters
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- branch_taken  in  1  taken branch resolved in MEM (BRANCH_MO)
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID register load enable
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB and the regfile write
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load NOP/zero control into the register
- halted  out  1  state == HALT
- state  out  2  00 HALT, 01 RUN, 10 STEP
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Active cycle: state is RUN, or state is STEP with remaining != 0.
- HALT: pc_en = if_id_en = pipe_en = 0 and all flushes are 0. The pipeline is frozen, and branch_taken and hazard inputs are ignored.
- Active cycle, default: pc_en = if_id_en = pipe_en = 1, flushes 0.
- Load-use hazard: ex_mem_read and ex_rd != 0 and ((id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd)).
  - Outputs: pc_en = 0, if_id_en = 0, id_ex_flush = 1, pipe_en = 1.
  - stall_count increments.
- Branch (active cycle with branch_taken):
  - Outputs: pc_en = 1 (loads the target), if_id_en = 1, if_id_flush = id_ex_flush = ex_mem_flush = 1, pipe_en = 1.
  - flush_count increments.
  - Branch has priority over load-use. The hazard is masked and stall_count does not increment.
- Transitions, evaluated each clock; priority is halt_req > run_req > step_req:
  - Any state + halt_req -> HALT, and remaining is cleared.
  - HALT or STEP + run_req -> RUN.
  - HALT + step_req -> STEP, with remaining = (step_num == 0) ? 1 : step_num.
  - step_req outside HALT is ignored.
  - STEP active cycle: remaining decrements. When remaining == 1, the next state is HALT.
- Steps count clock cycles, not retired instructions. Stall and flush cycles consume steps.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle, and the result is 0.
  - Counters only change on active cycles.
- Enables and flushes are combinational from the registered state and the current inputs. state, remaining and the counters are registered.

## Timing
- Reset (asynchronous, immediate):
  - state = START_RUN ? RUN : HALT, remaining = 0, counters = 0.
  - halted = !START_RUN.
  - With hazard inputs low, pc_en = if_id_en = pipe_en = START_RUN and all flushes are 0.
- Request latency: a request sampled at edge N changes state after N. Outputs reflect the new state in cycle N+1.
- Load-use stall lasts exactly 1 cycle. Next cycle ex_mem_read is 0 (bubble), so the hazard clears without internal state.
- Branch flush lasts 1 cycle per branch_taken assertion. No extra dead cycles.
- Step of k: exactly k consecutive active cycles, then halted = 1 from the following cycle.
- halt_req while a stall or flush is being asserted: the outputs of that cycle are still applied, and HALT freezes from the next cycle.
- Reset mid-step: the step is abandoned and state returns to its reset value.

## Test plan
- Reset with START_RUN=1, no hazards -> state=01, pc_en=if_id_en=pipe_en=1, flushes 0, counters 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_count=1. Repeat with ex_rd=0 -> no stall.
- branch_taken=1 together with a load-use match -> all three flushes=1, pc_en=1, flush_count=1, stall_count unchanged.
- halt_req, then step_req with step_num=3 -> exactly 3 cycles with pipe_en=1, then halted=1. step_num=0 -> exactly 1 cycle.
- Simultaneous halt_req+run_req in RUN -> HALT. step_req while in RUN -> ignored, state stays 01.
- CNT_W=2: force 5 load-use stalls -> stall_count saturates at 3. cnt_clr together with a stall -> 0. Assert rst mid-STEP (START_RUN=0) -> immediately HALT, counters 0.
